// File: rtl/alu_issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_queue: FIFO issue stage feeding a combinational ALU, with a    |
// | registered, handshaked result. Optional out_zero: ALU_ISSUE_ZERO_FLAG_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [2:0]       opcode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_opcode
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int ENTRY_W = 3 + 2 * WIDTH;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wp;
  logic [AW-1:0]      rp;
  logic [AW:0]        count;
  logic               hv;
  logic               free;
  logic               push;
  logic               pop;

  assign hv       = (count != '0);
  assign free     = !out_valid || out_ready;
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = hv && free;

  // Head is zeroed when empty so the ALU sees quiet operands.
  assign {opcode, a, b} = hv ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= {in_opcode, in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_opcode <= '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      out_zero   <= 1'b0;
`endif
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        out_y      <= y;
        out_opcode <= opcode;
        out_valid  <= 1'b1;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        out_zero   <= (y == '0);
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// Directed bench for alu_issue_queue with an XOR stand-in for the ALU.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [2:0] out_opcode;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic       out_zero;
`endif

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  logic [10:0] expq [$];

  assign y = a ^ b;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(4), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_opcode (out_opcode)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes seen before the edge, then sample #1 after it.
  task automatic tick();
    logic [10:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        delivered++;
        if (expq.size() == 0) begin
          chk("unexpected_result", {21'd0, out_opcode, out_y}, 32'h7FF);
        end else begin
          e = expq.pop_front();
          chk("result_order", {21'd0, out_opcode, out_y}, {21'd0, e});
        end
      end
      if (in_valid && in_ready) expq.push_back({in_opcode, in_a ^ in_b});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    in_valid  = v;
    in_opcode = op;
    in_a      = av;
    in_b      = bv;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_head", {13'd0, opcode, a, b}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_y", {24'd0, out_y}, 32'd0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
`endif

    // Single op: head in cycle 2, result in cycle 3
    drive(1'b1, 3'd3, 8'h5A, 8'h0F);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    chk("single_head", {13'd0, opcode, a, b}, {13'd0, 3'd3, 8'h5A, 8'h0F});
    chk("single_no_result_yet", {31'd0, out_valid}, 32'd0);
    tick();
    chk("single_out_valid", {31'd0, out_valid}, 32'd1);
    chk("single_out_y", {24'd0, out_y}, 32'h55);
    chk("single_out_opcode", {29'd0, out_opcode}, 32'd3);
    tick();
    chk("single_drained", {31'd0, out_valid}, 32'd0);

    // Fill with downstream stalled: 1 in result register + 4 in FIFO
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'(k), 8'h10 + 8'(k), 8'h01);
      chk("fill_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    drive(1'b1, 3'd5, 8'hC0, 8'h0C);
    for (int k = 0; k < 3; k++) begin
      chk("full_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("full_out_y_held", {24'd0, out_y}, 32'h11);
      tick();
    end
    out_ready = 1'b1;
    begin
      int guard;
      guard = 0;
      while (!(in_valid && in_ready) && guard < 8) begin
        tick();
        guard++;
      end
      chk("full_refill_accepted", {31'd0, in_ready}, 32'd1);
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) tick();
    chk("fill_all_delivered", 32'(delivered), 32'd7);
    chk("fill_queue_empty", 32'(expq.size()), 32'd0);

    // Streaming 8 ops crosses the pointer wrap
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(7 - k), 8'(k * 17), 8'hF0 - 8'(k));
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (k >= 1) chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    chk("stream_last_valid", {31'd0, out_valid}, 32'd1);
    chk("stream_last_y", {24'd0, out_y}, 32'h77 ^ 32'hE9);
    tick();
    chk("stream_done", {31'd0, out_valid}, 32'd0);
    chk("stream_delivered", 32'(delivered), 32'd15);

    // Stall with AA pending
    drive(1'b1, 3'd2, 8'hAA, 8'h00);
    tick();
    drive(1'b1, 3'd4, 8'h12, 8'h34);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 3'd6, 8'h0F, 8'hF0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_out_y", {24'd0, out_y}, 32'hAA);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_head", {13'd0, opcode, a, b}, {13'd0, 3'd4, 8'h12, 8'h34});
      tick();
      drive(1'b0, 3'd0, 8'h00, 8'h00);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_resume_y", {24'd0, out_y}, 32'h26);
    chk("stall_resume_op", {29'd0, out_opcode}, 32'd4);
    tick();
    chk("stall_third_y", {24'd0, out_y}, 32'hFF);
    tick();
    chk("stall_delivered", 32'(delivered), 32'd18);

    // Reset mid-operation with count=3 and out_valid=1
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd1, 8'(k + 1), 8'h80);
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_head", {13'd0, opcode, a, b}, {13'd0, 3'd1, 8'h02, 8'h80});
    rst = 1'b1;
    drive(1'b1, 3'd7, 8'hEE, 8'h11);
    tick();
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    expq.delete();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_y", {24'd0, out_y}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_head", {13'd0, opcode, a, b}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("midrst_stays_empty", {31'd0, out_valid}, 32'd0);

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    drive(1'b1, 3'd0, 8'h33, 8'h33);
    tick();
    drive(1'b1, 3'd0, 8'h01, 8'h00);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    chk("zero_y", {24'd0, out_y}, 32'd0);
    chk("zero_flag_set", {31'd0, out_zero}, 32'd1);
    tick();
    chk("zero_y2", {24'd0, out_y}, 32'd1);
    chk("zero_flag_clear", {31'd0, out_zero}, 32'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
